// File: rtl/core_bus_mux_pkg.sv
// Shared constants and select-code encoding for the core datapath bus mux.
package core_bus_pkg;

    localparam int unsigned DATA_W   = 16;
    localparam int unsigned NARROW_W = 8;
    localparam int unsigned SEL_W    = 5;

    typedef enum logic [SEL_W-1:0] {
        SEL_IDLE  = 5'd0,
        SEL_IR    = 5'd1,
        SEL_TR    = 5'd2,
        SEL_DR    = 5'd3,
        SEL_RA    = 5'd4,
        SEL_RB    = 5'd5,
        SEL_RO    = 5'd6,
        SEL_RN    = 5'd7,
        SEL_RP    = 5'd8,
        SEL_RC    = 5'd9,
        SEL_RR    = 5'd10,
        SEL_RT    = 5'd11,
        SEL_AC    = 5'd12,
        SEL_DRAM  = 5'd13,
        SEL_IRMTR = 5'd14,
        SEL_ACHI  = 5'd15,
        SEL_RCOL1 = 5'd16,
        SEL_RCOL2 = 5'd17
    } bus_sel_t;

    function automatic logic [DATA_W-1:0] zext(input logic [NARROW_W-1:0] v);
        return {{(DATA_W-NARROW_W){1'b0}}, v};
    endfunction

endpackage

// File: rtl/core_bus_mux_if.sv
// Bus source/select bundle between the core registers and the bus mux.
interface core_bus_mux_if;
    import core_bus_pkg::*;

    logic [SEL_W-1:0]    read_en;
    logic [NARROW_W-1:0] ir;
    logic [NARROW_W-1:0] tr;
    logic [NARROW_W-1:0] dr;
    logic [DATA_W-1:0]   ra;
    logic [DATA_W-1:0]   rb;
    logic [DATA_W-1:0]   ro;
    logic [NARROW_W-1:0] rcol1;
    logic [NARROW_W-1:0] rcol2;
    logic [NARROW_W-1:0] rn;
    logic [NARROW_W-1:0] rp;
    logic [NARROW_W-1:0] rc;
    logic [NARROW_W-1:0] rr;
    logic [DATA_W-1:0]   rt;
    logic [DATA_W-1:0]   ac;
    logic [NARROW_W-1:0] dram;
    logic [DATA_W-1:0]   busIn;

    modport master (
        output read_en, ir, tr, dr, ra, rb, ro, rcol1, rcol2,
               rn, rp, rc, rr, rt, ac, dram,
        input  busIn
    );

    modport slave (
        input  read_en, ir, tr, dr, ra, rb, ro, rcol1, rcol2,
               rn, rp, rc, rr, rt, ac, dram,
        output busIn
    );

endinterface

// File: rtl/core_bus_mux.sv
// Registered 16-bit datapath bus source multiplexer.
// Optional BUS_HOLD_UNUSED_EN: unused select codes hold busIn instead of clearing it.
module core_bus_mux
    import core_bus_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    core_bus_mux_if.slave   bus
);

    logic [DATA_W-1:0]   bus_next;
    logic [NARROW_W-1:0] ir_minus_tr;

    assign ir_minus_tr = bus.ir - bus.tr;

    always_comb begin
`ifdef BUS_HOLD_UNUSED_EN
        bus_next = bus.busIn;
`else
        bus_next = '0;
`endif
        // Unknown or unused codes fall through to the default above.
        case (bus.read_en)
            SEL_IR:    bus_next = zext(bus.ir);
            SEL_TR:    bus_next = zext(bus.tr);
            SEL_DR:    bus_next = zext(bus.dr);
            SEL_RA:    bus_next = bus.ra;
            SEL_RB:    bus_next = bus.rb;
            SEL_RO:    bus_next = bus.ro;
            SEL_RN:    bus_next = zext(bus.rn);
            SEL_RP:    bus_next = zext(bus.rp);
            SEL_RC:    bus_next = zext(bus.rc);
            SEL_RR:    bus_next = zext(bus.rr);
            SEL_RT:    bus_next = bus.rt;
            SEL_AC:    bus_next = bus.ac;
            SEL_DRAM:  bus_next = zext(bus.dram);
            SEL_IRMTR: bus_next = zext(ir_minus_tr);
            SEL_ACHI:  bus_next = zext(bus.ac[DATA_W-1:DATA_W-NARROW_W]);
            SEL_RCOL1: bus_next = zext(bus.rcol1);
            SEL_RCOL2: bus_next = zext(bus.rcol2);
            default:   ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.busIn <= '0;
        end else begin
            bus.busIn <= bus_next;
        end
    end

endmodule

// File: tb/tb_core_bus_mux.sv
// Self-checking bench for core_bus_mux: expected bus values queued at drive time, popped after each edge.
module tb_core_bus_mux;
    import core_bus_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    logic [15:0] sb[$];
    logic [15:0] exp_v;
    logic [15:0] last_v = 16'h0000;

    core_bus_mux_if bus ();

    core_bus_mux dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives the source that a given select code reads, truncating to its width.
    task automatic set_src(input int sel, input int v);
        case (sel)
            1:  bus.ir    = v[7:0];
            2:  bus.tr    = v[7:0];
            3:  bus.dr    = v[7:0];
            4:  bus.ra    = v[15:0];
            5:  bus.rb    = v[15:0];
            6:  bus.ro    = v[15:0];
            7:  bus.rn    = v[7:0];
            8:  bus.rp    = v[7:0];
            9:  bus.rc    = v[7:0];
            10: bus.rr    = v[7:0];
            11: bus.rt    = v[15:0];
            12: bus.ac    = v[15:0];
            13: bus.dram  = v[7:0];
            16: bus.rcol1 = v[7:0];
            17: bus.rcol2 = v[7:0];
            default: ;
        endcase
    endtask

    function automatic logic [15:0] model(input logic [4:0] s, input logic [15:0] prev);
        logic [7:0] d;
        d = bus.ir - bus.tr;
        case (s)
            5'd1:  return {8'h00, bus.ir};
            5'd2:  return {8'h00, bus.tr};
            5'd3:  return {8'h00, bus.dr};
            5'd4:  return bus.ra;
            5'd5:  return bus.rb;
            5'd6:  return bus.ro;
            5'd7:  return {8'h00, bus.rn};
            5'd8:  return {8'h00, bus.rp};
            5'd9:  return {8'h00, bus.rc};
            5'd10: return {8'h00, bus.rr};
            5'd11: return bus.rt;
            5'd12: return bus.ac;
            5'd13: return {8'h00, bus.dram};
            5'd14: return {8'h00, d};
            5'd15: return {8'h00, bus.ac[15:8]};
            5'd16: return {8'h00, bus.rcol1};
            5'd17: return {8'h00, bus.rcol2};
`ifdef BUS_HOLD_UNUSED_EN
            default: return prev;
`else
            default: return 16'h0000;
`endif
        endcase
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        bus.read_en = 5'd4;
        bus.ra = 16'd44;
        sb.push_back(16'h0000);
        tick();
        exp_v = sb.pop_front();
        checks++;
        if (bus.busIn !== exp_v) begin
            $display("FAIL reset_hold: got %h required %h", bus.busIn, exp_v);
            errors++;
        end
        rst_n = 1'b1;
        sb.push_back(16'd44);
        tick();
        exp_v = sb.pop_front();
        checks++;
        if (bus.busIn !== exp_v) begin
            $display("FAIL reset_release: got %h required %h", bus.busIn, exp_v);
            errors++;
        end
    endtask

    task automatic test_sources();
        int          sel [6] = '{1, 1, 3, 4, 6, 12};
        int          val [6] = '{255, 256, -2, 65533, 65536, 65537};
        logic [15:0] want[6] = '{16'h00FF, 16'h0000, 16'h00FE, 16'hFFFD, 16'h0000, 16'h0001};
        for (int i = 0; i < 6; i++) begin
            bus.read_en = sel[i][4:0];
            set_src(sel[i], val[i]);
            sb.push_back(want[i]);
            tick();
            exp_v = sb.pop_front();
            checks++;
            if (bus.busIn !== exp_v) begin
                $display("FAIL source_sel%0d_val%0d: got %h required %h", sel[i], val[i], bus.busIn, exp_v);
                errors++;
            end
        end
    endtask

    task automatic test_derived();
        bus.read_en = 5'd14;
        bus.ir = 8'd2;
        bus.tr = 8'd7;
        sb.push_back(16'h00FB);
        tick();
        exp_v = sb.pop_front();
        checks++;
        if (bus.busIn !== exp_v) begin
            $display("FAIL ir_minus_tr: got %h required %h", bus.busIn, exp_v);
            errors++;
        end
        bus.read_en = 5'd15;
        bus.ac = 16'b1100111000100001;
        sb.push_back(16'h00CE);
        tick();
        exp_v = sb.pop_front();
        checks++;
        if (bus.busIn !== exp_v) begin
            $display("FAIL ac_high: got %h required %h", bus.busIn, exp_v);
            errors++;
        end
    endtask

    task automatic test_isolation();
        bus.read_en = 5'd2;
        bus.tr = 8'd22;
        sb.push_back(16'd22);
        tick();
        exp_v = sb.pop_front();
        checks++;
        if (bus.busIn !== exp_v) begin
            $display("FAIL iso_select_tr: got %h required %h", bus.busIn, exp_v);
            errors++;
        end
        bus.ir = 8'd27;
        sb.push_back(16'd22);
        tick();
        exp_v = sb.pop_front();
        checks++;
        if (bus.busIn !== exp_v) begin
            $display("FAIL iso_ir_change: got %h required %h", bus.busIn, exp_v);
            errors++;
        end
        bus.tr = 8'd254;
        #1;
        checks++;
        if (bus.busIn !== 16'd22) begin
            $display("FAIL latency_before_edge: got %h required %h", bus.busIn, 16'd22);
            errors++;
        end
        sb.push_back(16'h00FE);
        tick();
        exp_v = sb.pop_front();
        checks++;
        if (bus.busIn !== exp_v) begin
            $display("FAIL latency_after_edge: got %h required %h", bus.busIn, exp_v);
            errors++;
        end
    endtask

    task automatic test_unused();
        logic [4:0] codes[3] = '{5'd0, 5'd20, 5'd31};
        logic [15:0] prev;
        bus.read_en = 5'd5;
        bus.rb = 16'hA5C3;
        tick();
        prev = 16'hA5C3;
        for (int i = 0; i < 3; i++) begin
            bus.read_en = codes[i];
`ifdef BUS_HOLD_UNUSED_EN
            sb.push_back(prev);
`else
            sb.push_back(16'h0000);
`endif
            tick();
            exp_v = sb.pop_front();
            checks++;
            if (bus.busIn !== exp_v) begin
                $display("FAIL unused_code%0d: got %h required %h", codes[i], bus.busIn, exp_v);
                errors++;
            end
        end
    endtask

    task automatic test_mid_reset();
        bus.read_en = 5'd12;
        bus.ac = 16'h1234;
        tick();
        rst_n = 1'b0;
        sb.push_back(16'h0000);
        tick();
        exp_v = sb.pop_front();
        checks++;
        if (bus.busIn !== exp_v) begin
            $display("FAIL mid_reset: got %h required %h", bus.busIn, exp_v);
            errors++;
        end
        rst_n = 1'b1;
        sb.push_back(16'h1234);
        tick();
        exp_v = sb.pop_front();
        checks++;
        if (bus.busIn !== exp_v) begin
            $display("FAIL post_reset_load: got %h required %h", bus.busIn, exp_v);
            errors++;
        end
        last_v = 16'h1234;
    endtask

    task automatic test_back_to_back();
        logic [4:0] s;
        for (int i = 0; i < 40; i++) begin
            s = 5'($urandom_range(0, 31));
            bus.read_en = s;
            for (int k = 1; k <= 17; k++) set_src(k, int'($urandom));
            bus.ac = 16'($urandom);
            bus.tr = 8'($urandom);
            exp_v = model(s, last_v);
            sb.push_back(exp_v);
            last_v = exp_v;
            tick();
            exp_v = sb.pop_front();
            checks++;
            if (bus.busIn !== exp_v) begin
                $display("FAIL random_sel%0d: got %h required %h", s, bus.busIn, exp_v);
                errors++;
            end
        end
    endtask

    initial begin
        bus.read_en = '0;
        bus.ir = '0; bus.tr = '0; bus.dr = '0; bus.ra = '0; bus.rb = '0;
        bus.ro = '0; bus.rcol1 = '0; bus.rcol2 = '0; bus.rn = '0; bus.rp = '0;
        bus.rc = '0; bus.rr = '0; bus.rt = '0; bus.ac = '0; bus.dram = '0;
        #1;
        test_reset();
        test_sources();
        test_derived();
        test_isolation();
        test_unused();
        test_mid_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
